rle_encoder: RTL
================

Name: rle_encoder

Overview:
- Run-length encoder directly downstream of the sample delay FIFO in the capture path.
- Consumes the delayed valid/data sample stream.
- Collapses runs of identical samples into one value word followed by one or more count words.
- Feeds the capture RAM writer; no backpressure exists anywhere in the stream.

Parameters:
WIDTH, 32, stream word width; bit WIDTH-1 is the count flag, so sample payload is bits WIDTH-2:0.
CNT_MAX, 2**(WIDTH-1)-1, saturation value of a count word.

Ports:
clock  input  1  capture clock; all state on posedge.
reset  input  1  asynchronous, active-low reset.
enable  input  1  1 = RLE mode, 0 = pass-through; static while capturing.
validIn  input  1  sample strobe from the delay FIFO.
dataIn  input  WIDTH  sample; bit WIDTH-1 is ignored in RLE mode.
flush  input  1  single-cycle request to drain outstanding words at end of capture.
validOut  output  1  word strobe to the RAM writer.
dataOut  output  WIDTH  encoded word.
flushDone  output  1  one-cycle pulse when the drain is complete.

Behaviour:
- Reset (reset=0, asynchronous): validOut=0, dataOut=0, flushDone=0, count=0, pending empty, state EMPTY.
- Latency: every emitted word is registered, 1 clock after the causing input.
- Pass-through (enable=0): validOut/dataOut = validIn/dataIn delayed by 1 clock; no encoding; flush pulses flushDone next cycle.
- Value word = {1'b0, payload}. Count word = {1'b1, repeats}, where repeats counts additional identical samples.
- States:
  - EMPTY (no current value).
  - RUN (current value held, count >= 0).
  - FLUSH (draining).
- EMPTY + validIn: emit the value word; current <= payload; go to RUN.
- RUN + validIn, payload == current: count++, no output.
  - If count reaches CNT_MAX: emit the count word this cycle, count <= 0, stay in RUN (value is not re-emitted). The consumer sums consecutive count words.
- RUN + validIn, payload != current:
  - If count > 0: emit the count word; the new payload goes into the 1-entry pending register.
  - If count == 0: emit the new value word directly (unless pending is occupied, see below).
  - In both cases current <= payload, count <= 0.
- Pending occupied in any cycle: the pending word has output priority.
  - A new value word that collides with it replaces pending (depth 1 is always sufficient).
  - A matching repeat increments count while the pending word is emitted.
- Cycles with no validIn: pending (if any) is emitted.
- flush sampled high: go to FLUSH.
  - Emit the pending word, if any, on the next cycle.
  - Then emit the count word if count > 0.
  - Then pulse flushDone for 1 cycle and go to EMPTY.
  - If nothing is outstanding, flushDone asserts 1 cycle after flush.
- validIn during FLUSH or in the same cycle as flush: the sample is dropped (the capture controller guarantees this does not occur).
- Payload comparison covers bits WIDTH-2:0 only.
- Reset mid-run discards current, count and pending; no partial word is emitted.

Optional Feature:
RLE_GROUP_MASK_EN
- With the macro: adds input disabledGroups[3:0] (WIDTH=32 only).
  - Byte lanes with their bit set are excluded from the equality compare.
  - Those lanes are forced to 0 in emitted value words.
  - disabledGroups is static during capture.
- Without the macro: no port; all payload bits are compared and emitted.

Decomposition:
- Shared package:
  - count-flag bit position, CNT_MAX, state encoding (EMPTY/RUN/FLUSH).
  - helper function building the count/value word.
- One natural sub-module: rle_run_counter.
  - Saturating counter with clear, increment and at-max flag.
  - Same clock/reset ports as the encoder.

Test Plan:
- Pass-through: enable=0, samples 0x11,0x22,0x33 on consecutive cycles -> validOut the same three words 1 cycle later, unchanged.
- Basic run: enable=1, samples 0x05 x4 then 0x07, then flush -> words 0x00000005, 0x80000003, 0x00000007; flushDone 1 cycle after the last word.
- Back-to-back change: A,A,B,C then idle -> 0x0..A, 0x80000001, 0x0..B, 0x0..C on 4 consecutive output cycles; no word lost.
- Saturation: force WIDTH=8 (CNT_MAX=127), 129 identical 0x2A -> 0x2A, 0xFF (127), then on flush 0x81.
- Flush edge: flush with nothing outstanding -> flushDone next cycle, validOut=0. Reset asserted mid-run -> outputs 0 immediately; the next sample is emitted as a fresh value word.
- RLE_GROUP_MASK_EN: disabledGroups=4'b1000, samples 0x01000005 then 0xFF000005 -> treated as a repeat; on flush, words 0x00000005, 0x80000001.

Source files
------------

// File: rtl/rle_encoder_pkg.sv
// Shared definitions for the capture-path run-length encoder: state encoding,
// count-word saturation value and the value/count word builder.
package rle_encoder_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rle_state_e;

  function automatic int unsigned cnt_flag_pos(input int unsigned width);
    return width - 1;
  endfunction

  function automatic logic [MAX_W-1:0] cnt_max(input int unsigned width);
    return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

  // Count words carry the flag in the top bit; value words clear it.
  function automatic logic [MAX_W-1:0] rle_word(input logic is_count,
                                                input logic [MAX_W-1:0] body,
                                                input int unsigned width);
    logic [MAX_W-1:0] w;
    w = body & cnt_max(width);
    w[cnt_flag_pos(width)] = is_count;
    return w;
  endfunction

endpackage

// File: rtl/rle_run_counter.sv
// Saturating repeat counter for the RLE encoder; at_max flags that the next
// increment lands on CNT_MAX.
module rle_run_counter
  import rle_encoder_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-2:0] CNT_MAX = (WIDTH-1)'(cnt_max(WIDTH))
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-2:0] count,
  output logic             at_max
);

  logic [WIDTH-2:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == (CNT_MAX - 1'b1));

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder between the sample delay FIFO and the capture RAM writer.
// Optional byte-lane compare masking is enabled with RLE_GROUP_MASK_EN.
module rle_encoder
  import rle_encoder_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-2:0] CNT_MAX = (WIDTH-1)'(cnt_max(WIDTH))
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             validIn,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             flush,
`ifdef RLE_GROUP_MASK_EN
  input  logic [3:0]       disabledGroups,
`endif
  output logic             validOut,
  output logic [WIDTH-1:0] dataOut,
  output logic             flushDone
);

  localparam int unsigned PW = WIDTH - 1;

  rle_state_e       state_q, state_d;
  logic [PW-1:0]    cur_q, cur_d;
  logic             pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;

  logic             cnt_clr, cnt_inc, cnt_at_max;
  logic [PW-1:0]    count;
  logic [PW-1:0]    lane_mask, payload;
  logic             w1_vld, w2_vld;
  logic [WIDTH-1:0] w1, w2;

`ifdef RLE_GROUP_MASK_EN
  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      if ((i / 8) < 4) lane_mask[i] = disabledGroups[2'(i / 8)];
    end
  end
`else
  assign lane_mask = '0;
`endif

  assign payload = dataIn[PW-1:0] & ~lane_mask;

  function automatic logic [WIDTH-1:0] value_word(input logic [PW-1:0] p);
    return WIDTH'(rle_word(1'b0, MAX_W'(p), WIDTH));
  endfunction

  function automatic logic [WIDTH-1:0] count_word(input logic [PW-1:0] c);
    return WIDTH'(rle_word(1'b1, MAX_W'(c), WIDTH));
  endfunction

  rle_run_counter #(
    .WIDTH   (WIDTH),
    .CNT_MAX (CNT_MAX)
  ) u_run_counter (
    .clock  (clock),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .count  (count),
    .at_max (cnt_at_max)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    done_d     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    w1_vld     = 1'b0;
    w1         = '0;
    w2_vld     = 1'b0;
    w2         = '0;

    if (!enable) begin
      valid_d    = validIn;
      data_d     = dataIn;
      done_d     = flush;
      state_d    = EMPTY;
      pend_vld_d = 1'b0;
      cnt_clr    = 1'b1;
    end else if (flush || (state_q == FLUSH)) begin
      // One drain step per cycle: pending word, then count word, then done.
      if (pend_vld_q) begin
        valid_d    = 1'b1;
        data_d     = pend_q;
        pend_vld_d = 1'b0;
        state_d    = FLUSH;
      end else if (count != '0) begin
        valid_d = 1'b1;
        data_d  = count_word(count);
        cnt_clr = 1'b1;
        state_d = FLUSH;
      end else begin
        done_d  = 1'b1;
        state_d = EMPTY;
      end
    end else begin
      if (validIn) begin
        if (state_q == EMPTY) begin
          w1_vld  = 1'b1;
          w1      = value_word(payload);
          cur_d   = payload;
          cnt_clr = 1'b1;
          state_d = RUN;
        end else if (payload == cur_q) begin
          if (cnt_at_max) begin
            w1_vld  = 1'b1;
            w1      = count_word(CNT_MAX);
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end else begin
          cur_d   = payload;
          cnt_clr = 1'b1;
          w1_vld  = 1'b1;
          if (count != '0) begin
            w1     = count_word(count);
            w2_vld = 1'b1;
            w2     = value_word(payload);
          end else begin
            w1 = value_word(payload);
          end
        end
      end
      // Pending is only ever occupied while count is zero, so w2 cannot be
      // produced in the same cycle and one pending slot suffices.
      if (pend_vld_q) begin
        valid_d    = 1'b1;
        data_d     = pend_q;
        pend_vld_d = w1_vld;
        pend_d     = w1;
      end else begin
        valid_d    = w1_vld;
        if (w1_vld) data_d = w1;
        pend_vld_d = w2_vld;
        pend_d     = w2;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      cur_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      done_q     <= done_d;
    end
  end

  assign validOut  = valid_q;
  assign dataOut   = data_q;
  assign flushDone = done_q;

endmodule
